// File: rtl/dmem_responder_if.sv
// MEM-stage load/store bus between the CPU (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int DSIZE  = 32,
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DSIZE-1:0]  req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DSIZE-1:0]  resp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with WAIT_CYCLES wait states per access.
// Define DMEM_POSTED_WRITE_EN to post writes at acceptance with no response.
module dmem_responder #(
  parameter int DSIZE       = 32,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DSIZE-1:0]  wdata_q;
  logic [DSIZE-1:0]  mem [2**ADDR_W];

  logic              accept, access, posted;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DSIZE-1:0]  mem_wdata;

  assign accept = (state == S_IDLE) && bus.req_valid && bus.req_ready;
  assign access = (state == S_WAIT) && (cnt == 4'd0);

`ifdef DMEM_POSTED_WRITE_EN
  assign posted = accept && bus.req_wen;
`else
  assign posted = 1'b0;
`endif

  // Posted writes take the bus fields directly; full-flow writes use the latched copy.
  assign mem_we    = posted || (access && wen_q);
  assign mem_waddr = posted ? bus.req_addr  : addr_q;
  assign mem_wdata = posted ? bus.req_wdata : wdata_q;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      wen_q          <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && !posted) begin
            wen_q         <= bus.req_wen;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            cnt           <= WAIT_INIT;
            bus.req_ready <= 1'b0;
            state         <= S_WAIT;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            bus.resp_rdata <= wen_q ? '0 : mem[addr_q];
            bus.resp_valid <= 1'b1;
            state          <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 wait states and 0 wait states) on a
// shared clock/reset, checked against a per-instance word-array model.
module tb_dmem_responder;
  logic clk, rst;
  logic        rv [2];
  logic        wn [2];
  logic [7:0]  ad [2];
  logic [31:0] wd [2];
  logic        rr [2];

  logic [31:0] model [2][256];
  bit          known [2][256];
  int checks = 0, passes = 0;

  dmem_responder_if #(.DSIZE(32), .ADDR_W(8)) if0 ();
  dmem_responder_if #(.DSIZE(32), .ADDR_W(8)) if1 ();

  assign if0.req_valid = rv[0]; assign if1.req_valid = rv[1];
  assign if0.req_wen   = wn[0]; assign if1.req_wen   = wn[1];
  assign if0.req_addr  = ad[0]; assign if1.req_addr  = ad[1];
  assign if0.req_wdata = wd[0]; assign if1.req_wdata = wd[1];
  assign if0.resp_ready = rr[0]; assign if1.resp_ready = rr[1];

  dmem_responder #(.DSIZE(32), .ADDR_W(8), .WAIT_CYCLES(2)) u0 (.clk(clk), .rst(rst), .bus(if0));
  dmem_responder #(.DSIZE(32), .ADDR_W(8), .WAIT_CYCLES(0)) u1 (.clk(clk), .rst(rst), .bus(if1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic get_rdy(int s);
    return (s != 0) ? if1.req_ready : if0.req_ready;
  endfunction
  function automatic logic get_vld(int s);
    return (s != 0) ? if1.resp_valid : if0.resp_valid;
  endfunction
  function automatic logic [31:0] get_rd(int s);
    return (s != 0) ? if1.resp_rdata : if0.resp_rdata;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Starts and ends just after a falling edge. Latency is counted in rising edges
  // after the acceptance edge; the model says resp_valid rises at E0+WAIT+1.
  task automatic txn(input int s, input bit w, input logic [7:0] a,
                     input logic [31:0] d, input int stall);
    int lat;
    logic [31:0] exp;
    chk("idle_ready", 32'(get_rdy(s)), 32'd1);
    rv[s] = 1'b1; wn[s] = w; ad[s] = a; wd[s] = d; rr[s] = (stall == 0);
    @(negedge clk);
    rv[s] = 1'b0; wn[s] = 1'($urandom); ad[s] = 8'($urandom); wd[s] = $urandom;
`ifdef DMEM_POSTED_WRITE_EN
    if (w) begin
      chk("posted_ready", 32'(get_rdy(s)), 32'd1);
      chk("posted_no_resp", 32'(get_vld(s)), 32'd0);
      model[s][a] = d; known[s][a] = 1'b1; rr[s] = 1'b1;
      return;
    end
`endif
    chk("busy_ready", 32'(get_rdy(s)), 32'd0);
    lat = 0;
    while (!get_vld(s) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), (s == 0) ? 32'd3 : 32'd1);
    if (w) begin
      exp = 32'd0;
      model[s][a] = d; known[s][a] = 1'b1;
    end else begin
      exp = model[s][a];
    end
    if (w || known[s][a]) chk("rdata", get_rd(s), exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(get_vld(s)), 32'd1);
      chk("hold_ready", 32'(get_rdy(s)), 32'd0);
      if (w || known[s][a]) chk("hold_rdata", get_rd(s), exp);
    end
    rr[s] = 1'b1;
    @(negedge clk);
    chk("done_valid", 32'(get_vld(s)), 32'd0);
    chk("done_ready", 32'(get_rdy(s)), 32'd1);
  endtask

  initial begin
    logic [7:0] ra;
    bit rw;
    int rs;
    for (int s = 0; s < 2; s++) begin
      rv[s] = 1'b0; wn[s] = 1'b0; ad[s] = '0; wd[s] = '0; rr[s] = 1'b1;
      for (int k = 0; k < 256; k++) begin
        model[s][k] = '0; known[s][k] = 1'b0;
      end
    end

    // reset: outputs at reset values, req_ready rises one edge after release
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 32'(get_rdy(s)), 32'd0);
      chk("rst_valid", 32'(get_vld(s)), 32'd0);
      chk("rst_rdata", get_rd(s), 32'd0);
    end
    rst = 1'b1;
    #1 chk("rel_ready_early", 32'(get_rdy(0)), 32'd0);
    @(negedge clk);
    chk("rel_ready", 32'(get_rdy(0)), 32'd1);
    chk("rel_ready_w0", 32'(get_rdy(1)), 32'd1);

    // write then read, then backpressured read
    txn(0, 1'b1, 8'h05, 32'hDEADBEEF, 0);
    txn(0, 1'b0, 8'h05, 32'h0, 0);
    txn(0, 1'b0, 8'h05, 32'h0, 5);

    // zero wait states
    txn(1, 1'b1, 8'h00, 32'h00001234, 0);
    txn(1, 1'b0, 8'h00, 32'h0, 0);
    txn(1, 1'b1, 8'hFF, 32'hA5A5_0F0F, 2);
    txn(1, 1'b0, 8'hFF, 32'h0, 1);

    // reset during WAIT discards the pending write
    txn(0, 1'b1, 8'h10, 32'h0, 0);
    rv[0] = 1'b1; wn[0] = 1'b1; ad[0] = 8'h10; wd[0] = 32'hAAAA5555;
    @(negedge clk);
    rv[0] = 1'b0;
`ifdef DMEM_POSTED_WRITE_EN
    model[0][8'h10] = 32'hAAAA5555;
`endif
    rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(get_rdy(0)), 32'd0);
    chk("midrst_valid", 32'(get_vld(0)), 32'd0);
    chk("midrst_rdata", get_rd(0), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    txn(0, 1'b0, 8'h10, 32'h0, 0);
    txn(0, 1'b0, 8'h05, 32'h0, 0);

    // four consecutive writes then readback (posted or full-flow)
    for (int k = 1; k <= 4; k++) txn(0, 1'b1, 8'(k), 32'(k), 0);
    for (int k = 1; k <= 4; k++) txn(0, 1'b0, 8'(k), 32'h0, 0);

    // randomized traffic over a small address window to force reuse
    for (int n = 0; n < 40; n++) begin
      rs = int'($urandom_range(0, 1));
      ra = 8'h20 + 8'($urandom_range(0, 15));
      rw = !known[rs][ra] || ($urandom_range(0, 1) == 1);
      txn(rs, rw, ra, $urandom, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
